// File: rtl/feedback_pkg.sv
// Shared types and defaults for the clause feedback scheduler.
`timescale 1ns/1ps
package feedback_pkg;
  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ISSUE  = 2'd1,
    ST_WAIT   = 2'd2,
    ST_COMMIT = 2'd3
  } fb_state_e;

  localparam logic CFG_SEL_STATE  = 1'b0;
  localparam logic CFG_SEL_WEIGHT = 1'b1;

  localparam logic [7:0] DEF_STATE_INIT  = 8'h7F;
  localparam logic [7:0] DEF_WEIGHT_INIT = 8'h01;
endpackage

// File: rtl/feedback_sched_fsm.sv
// Sample sequencing FSM: handshake, datapath enable pulse, latency wait and commit strobe.
// state  | meaning
// IDLE   | ready for a sample or a config access
// ISSUE  | fb_en pulse, latency counter loaded
// WAIT   | waiting out the rest of the datapath latency
// COMMIT | datapath outputs valid, registers load at closing edge
`timescale 1ns/1ps
module feedback_sched_fsm
  import feedback_pkg::*;
#(
  parameter int FB_LATENCY = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic s_valid,
  input  logic cfg_we,
  output logic s_ready,
  output logic accept,
  output logic cfg_ok,
  output logic fb_en,
  output logic busy,
  output logic done
);
  fb_state_e state_q, state_d;
  logic [3:0] cnt_q, cnt_d;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      cnt_q   <= 4'd0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    s_ready = 1'b0;
    fb_en   = 1'b0;
    busy    = 1'b0;
    done    = 1'b0;
    case (state_q)
      ST_IDLE: begin
        s_ready = ~cfg_we;
        if (s_valid && !cfg_we) state_d = ST_IDLE == ST_IDLE ? ST_ISSUE : ST_IDLE;
      end
      ST_ISSUE: begin
        fb_en   = 1'b1;
        busy    = 1'b1;
        cnt_d   = 4'(FB_LATENCY - 1);
        // ISSUE is itself the first latency cycle, so short latencies skip WAIT
        state_d = (FB_LATENCY > 2) ? ST_WAIT : ST_COMMIT;
      end
      ST_WAIT: begin
        busy  = 1'b1;
        cnt_d = cnt_q - 4'd1;
        if (cnt_q <= 4'd2) state_d = ST_COMMIT;
      end
      ST_COMMIT: begin
        busy    = 1'b1;
        done    = 1'b1;
        cnt_d   = 4'd0;
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  assign accept = s_valid & s_ready;
  assign cfg_ok = cfg_we & (state_q == ST_IDLE);
endmodule

// File: rtl/feedback_scheduler.sv
// Clause feedback sequencer: owns automaton state and clause weight banks, drives the datapath.
// Optional commit counter enabled by FEEDBACK_SCHED_PERF_CNT_EN.
`timescale 1ns/1ps
module feedback_scheduler
  import feedback_pkg::*;
#(
  parameter int CLAUSE_NUM   = 4,
  parameter int LITERAL_NUM  = 8,
  parameter int STATE_WIDTH  = 8,
  parameter int WEIGHT_WIDTH = 8,
  parameter int FB_LATENCY   = 2,
  parameter logic [STATE_WIDTH-1:0]  STATE_INIT  = DEF_STATE_INIT,
  parameter logic [WEIGHT_WIDTH-1:0] WEIGHT_INIT = DEF_WEIGHT_INIT
) (
  input  logic                                 clk,
  input  logic                                 rst_n,
  input  logic                                 s_valid,
  output logic                                 s_ready,
  input  logic [LITERAL_NUM-1:0]               s_literals,
  input  logic [CLAUSE_NUM-1:0]                s_conj,
  output logic                                 fb_en,
  output logic [LITERAL_NUM-1:0]               fb_literals,
  output logic [CLAUSE_NUM-1:0]                fb_conj,
  output logic [LITERAL_NUM-1:0]               fb_actions,
  output logic [LITERAL_NUM*STATE_WIDTH-1:0]   fb_state_in,
  output logic [CLAUSE_NUM*WEIGHT_WIDTH-1:0]   fb_weight_in,
  input  logic [LITERAL_NUM*STATE_WIDTH-1:0]   fb_state_out,
  input  logic [CLAUSE_NUM*WEIGHT_WIDTH-1:0]   fb_weight_out,
  input  logic                                 cfg_we,
  input  logic                                 cfg_sel,
  input  logic [$clog2(LITERAL_NUM)-1:0]       cfg_addr,
  input  logic [STATE_WIDTH-1:0]               cfg_wdata,
  output logic [STATE_WIDTH-1:0]               cfg_rdata,
  output logic                                 busy,
  output logic                                 done,
  output logic [31:0]                          update_cnt
);
  localparam int WAW = $clog2(CLAUSE_NUM);

  logic accept, cfg_ok;
  logic [STATE_WIDTH-1:0]  state_r  [LITERAL_NUM];
  logic [WEIGHT_WIDTH-1:0] weight_r [CLAUSE_NUM];
  logic state_hit, weight_hit;

  feedback_sched_fsm #(.FB_LATENCY(FB_LATENCY)) u_fsm (
    .clk     (clk),
    .rst_n   (rst_n),
    .s_valid (s_valid),
    .cfg_we  (cfg_we),
    .s_ready (s_ready),
    .accept  (accept),
    .cfg_ok  (cfg_ok),
    .fb_en   (fb_en),
    .busy    (busy),
    .done    (done)
  );

  assign state_hit  = (cfg_sel == CFG_SEL_STATE)  && (int'(cfg_addr) < LITERAL_NUM);
  assign weight_hit = (cfg_sel == CFG_SEL_WEIGHT) && (int'(cfg_addr) < CLAUSE_NUM);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < LITERAL_NUM; i++) state_r[i] <= STATE_INIT;
      for (int j = 0; j < CLAUSE_NUM; j++) weight_r[j] <= WEIGHT_INIT;
      fb_literals <= '0;
      fb_conj     <= '0;
    end else begin
      if (accept) begin
        fb_literals <= s_literals;
        fb_conj     <= s_conj;
      end
      if (done) begin
        for (int i = 0; i < LITERAL_NUM; i++)
          state_r[i] <= fb_state_out[i*STATE_WIDTH +: STATE_WIDTH];
        for (int j = 0; j < CLAUSE_NUM; j++)
          weight_r[j] <= fb_weight_out[j*WEIGHT_WIDTH +: WEIGHT_WIDTH];
      end else if (cfg_ok) begin
        if (state_hit)  state_r[cfg_addr] <= cfg_wdata;
        if (weight_hit) weight_r[cfg_addr[WAW-1:0]] <= cfg_wdata[WEIGHT_WIDTH-1:0];
      end
    end
  end

  always_comb begin
    cfg_rdata = '0;
    if (state_hit)       cfg_rdata = state_r[cfg_addr];
    else if (weight_hit) cfg_rdata[WEIGHT_WIDTH-1:0] = weight_r[cfg_addr[WAW-1:0]];
  end

  for (genvar g = 0; g < LITERAL_NUM; g++) begin : g_state
    assign fb_state_in[g*STATE_WIDTH +: STATE_WIDTH] = state_r[g];
    assign fb_actions[g] = state_r[g][STATE_WIDTH-1];
  end
  for (genvar g = 0; g < CLAUSE_NUM; g++) begin : g_weight
    assign fb_weight_in[g*WEIGHT_WIDTH +: WEIGHT_WIDTH] = weight_r[g];
  end

`ifdef FEEDBACK_SCHED_PERF_CNT_EN
  logic [31:0] upd_q;
  always_ff @(posedge clk) begin
    if (!rst_n)    upd_q <= 32'd0;
    else if (done) upd_q <= upd_q + 32'd1;
  end
  assign update_cnt = upd_q;
`else
  assign update_cnt = 32'd0;
`endif
endmodule

// File: tb/tb_feedback_scheduler.sv
// Directed self-checking bench for feedback_scheduler with a constant datapath stub.
`timescale 1ns/1ps
module tb_feedback_scheduler;
`ifdef FEEDBACK_SCHED_PERF_CNT_EN
  localparam int PERF = 1;
`else
  localparam int PERF = 0;
`endif

  logic        clk = 1'b0;
  logic        rst_n, s_valid, s_ready, fb_en, cfg_we, cfg_sel, busy, done;
  logic [7:0]  s_literals, fb_literals, fb_actions, cfg_wdata, cfg_rdata;
  logic [3:0]  s_conj, fb_conj;
  logic [63:0] fb_state_in, fb_state_out;
  logic [31:0] fb_weight_in, fb_weight_out, update_cnt;
  logic [2:0]  cfg_addr;

  int checks = 0;
  int failures = 0;
  int en_seen;
  int en_at[2];
  logic [31:0] cnt_before;

  always #5 clk = ~clk;

  feedback_scheduler dut (
    .clk(clk), .rst_n(rst_n), .s_valid(s_valid), .s_ready(s_ready),
    .s_literals(s_literals), .s_conj(s_conj), .fb_en(fb_en),
    .fb_literals(fb_literals), .fb_conj(fb_conj), .fb_actions(fb_actions),
    .fb_state_in(fb_state_in), .fb_weight_in(fb_weight_in),
    .fb_state_out(fb_state_out), .fb_weight_out(fb_weight_out),
    .cfg_we(cfg_we), .cfg_sel(cfg_sel), .cfg_addr(cfg_addr),
    .cfg_wdata(cfg_wdata), .cfg_rdata(cfg_rdata), .busy(busy),
    .done(done), .update_cnt(update_cnt)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst_n = 1'b0; s_valid = 1'b0; s_literals = '0; s_conj = '0;
    cfg_we = 1'b0; cfg_sel = 1'b0; cfg_addr = '0; cfg_wdata = '0;
    fb_state_out  = 64'h0202030306060707;
    fb_weight_out = 32'h02020404;

    // reset
    step();
    rst_n = 1'b1;
    #1;
    check("rst_state",  fb_state_in, 64'h7F7F7F7F7F7F7F7F);
    check("rst_weight", 64'(fb_weight_in), 64'h01010101);
    check("rst_actions", 64'(fb_actions), 64'h00);
    check("rst_ready",  64'(s_ready), 64'd1);
    check("rst_busy",   64'(busy), 64'd0);
    check("rst_cnt",    64'(update_cnt), 64'd0);

    // config load
    cfg_we = 1'b1; cfg_sel = 1'b0;
    for (int i = 0; i < 8; i++) begin
      cfg_addr = 3'(i); cfg_wdata = 8'(8 - i);
      #1;
      if (i == 0) check("cfg_ready_low", 64'(s_ready), 64'd0);
      step();
    end
    cfg_sel = 1'b1;
    for (int i = 0; i < 4; i++) begin
      cfg_addr = 3'(i); cfg_wdata = 8'(4 - i);
      step();
    end
    cfg_we = 1'b0;
    #1;
    check("cfg_state",  fb_state_in, 64'h0102030405060708);
    check("cfg_weight", 64'(fb_weight_in), 64'h01020304);
    cfg_sel = 1'b0; cfg_addr = 3'd2; #1;
    check("cfg_rd_state2", 64'(cfg_rdata), 64'h06);
    cfg_sel = 1'b1; cfg_addr = 3'd1; #1;
    check("cfg_rd_weight1", 64'(cfg_rdata), 64'h03);

    // single update
    s_valid = 1'b1; s_literals = 8'hAA; s_conj = 4'hA;
    step();
    s_valid = 1'b0;
    check("t1_fb_en",  64'(fb_en), 64'd1);
    check("t1_done",   64'(done), 64'd0);
    check("t1_lits",   64'(fb_literals), 64'hAA);
    check("t1_conj",   64'(fb_conj), 64'hA);
    check("t1_ready",  64'(s_ready), 64'd0);
    step();
    check("t2_fb_en",  64'(fb_en), 64'd0);
    check("t2_done",   64'(done), 64'd1);
    check("t2_state_stable", fb_state_in, 64'h0102030405060708);
    step();
    check("t3_done",   64'(done), 64'd0);
    check("t3_busy",   64'(busy), 64'd0);
    check("t3_ready",  64'(s_ready), 64'd1);
    check("t3_state",  fb_state_in, 64'h0202030306060707);
    check("t3_weight", 64'(fb_weight_in), 64'h02020404);
    check("t3_cnt",    64'(update_cnt), 64'(PERF));

    // back-to-back
    cnt_before = update_cnt;
    s_valid = 1'b1; s_literals = 8'h55; s_conj = 4'h5;
    en_seen = 0; en_at[0] = -1; en_at[1] = -1;
    step();
    for (int i = 0; i < 8; i++) begin
      if (fb_en) begin
        if (en_seen < 2) en_at[en_seen] = i;
        en_seen++;
        if (en_seen == 2) s_valid = 1'b0;
      end
      step();
    end
    s_valid = 1'b0;
    check("b2b_pulses", 64'(en_seen), 64'd2);
    check("b2b_spacing", 64'(en_at[1] - en_at[0]), 64'd3);
    check("b2b_cnt_delta", 64'(update_cnt - cnt_before), 64'(2 * PERF));
    check("b2b_lits", 64'(fb_literals), 64'h55);

    // collision: cfg write wins, sample accepted next cycle
    cfg_we = 1'b1; cfg_sel = 1'b0; cfg_addr = 3'd3; cfg_wdata = 8'h80;
    s_valid = 1'b1; s_literals = 8'h0F; s_conj = 4'h3;
    #1;
    check("col_ready_low", 64'(s_ready), 64'd0);
    step();
    cfg_we = 1'b0;
    #1;
    check("col_busy", 64'(busy), 64'd0);
    check("col_state", fb_state_in, 64'h0202030380060707);
    check("col_actions", 64'(fb_actions), 64'h08);
    check("col_ready", 64'(s_ready), 64'd1);
    step();
    s_valid = 1'b0;
    check("col_fb_en", 64'(fb_en), 64'd1);
    check("col_lits", 64'(fb_literals), 64'h0F);
    cfg_we = 1'b1; cfg_addr = 3'd0; cfg_wdata = 8'hFF;
    step();
    check("busy_cfg_dropped", fb_state_in, 64'h0202030380060707);
    check("busy_done", 64'(done), 64'd1);
    cfg_we = 1'b0;
    step();
    check("col_commit", fb_state_in, 64'h0202030306060707);

    // reset while busy
    s_valid = 1'b1; s_literals = 8'hF0; s_conj = 4'hF;
    step();
    s_valid = 1'b0;
    check("rmid_busy", 64'(busy), 64'd1);
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    #1;
    check("rmid_done", 64'(done), 64'd0);
    check("rmid_idle", 64'(busy), 64'd0);
    check("rmid_ready", 64'(s_ready), 64'd1);
    check("rmid_state", fb_state_in, 64'h7F7F7F7F7F7F7F7F);
    check("rmid_weight", 64'(fb_weight_in), 64'h01010101);
    check("rmid_lits", 64'(fb_literals), 64'h00);
    check("rmid_cnt", 64'(update_cnt), 64'd0);
    step();
    check("rmid_no_done", 64'(done), 64'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end
endmodule
